// File: rtl/svi_rr_write_arbiter_if.sv
// Requester-side bus of the round-robin write arbiter: request/lock/data in, grant and
// shared-register state out.
interface svi_rr_write_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8
);
  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   i_req;
  logic [N_REQ-1:0]   i_lock;
  logic [N_REQ*W-1:0] i_wdata;
  logic [N_REQ-1:0]   o_gnt;
  logic [IW-1:0]      o_owner;
  logic [W-1:0]       o_q;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    output i_req, i_lock, i_wdata,
    input  o_gnt, o_owner, o_q, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_lock, i_wdata,
    output o_gnt, o_owner, o_q, o_busy, o_timeout
  );
endinterface

// File: rtl/svi_rr_write_arbiter.sv
// Round-robin arbiter owning one shared write register, with optional burst lock.
// Define RR_ARB_LOCK_TIMEOUT_EN to bound LOCK at LOCK_MAX cycles with a forced release.
module svi_rr_write_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input logic                   i_clk,
  input logic                   i_rst,
  svi_rr_write_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || LOCK_MAX < 1) begin : g_param_check
    $error("svi_rr_write_arbiter: N_REQ must be 2..8 and LOCK_MAX at least 1");
  end

  typedef enum logic [1:0] {StIdle, StGnt, StLock} state_e;

  state_e           state_q;
  logic [IW-1:0]    ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    owner_q;
  logic [W-1:0]     q_q;
  logic             busy_q;

  logic [W-1:0]     wdata_arr [N_REQ];
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr_next;
  logic             win_valid;
  logic             owner_hold;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign wdata_arr[k] = bus.i_wdata[k*W +: W];
  end

  // First requester at or after ptr, wrapping; deliberately blind to i_lock.
  always_comb begin
    int unsigned idx;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_valid && bus.i_req[IW'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign ptr_next   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
  assign owner_hold = bus.i_req[owner_q] && bus.i_lock[owner_q];

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt_q;
  logic          timeout_q;
  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      owner_q    <= '0;
      q_q        <= '0;
      busy_q     <= 1'b0;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_LOCK_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            gnt_q   <= N_REQ'(1) << win_idx;
            owner_q <= win_idx;
            q_q     <= wdata_arr[win_idx];
            ptr_q   <= ptr_next;
            busy_q  <= 1'b1;
            state_q <= StGnt;
          end
        end
        StGnt: begin
          if (owner_hold) begin
            q_q        <= wdata_arr[owner_q];
            state_q    <= StLock;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
            lock_cnt_q <= CW'(1);
`endif
          end else begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StLock: begin
          if (owner_hold) begin
`ifdef RR_ARB_LOCK_TIMEOUT_EN
            if (lock_cnt_q == CW'(LOCK_MAX)) begin
              gnt_q     <= '0;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              q_q        <= wdata_arr[owner_q];
              lock_cnt_q <= lock_cnt_q + CW'(1);
            end
`else
            q_q <= wdata_arr[owner_q];
`endif
          end else begin
            // Exit edge leaves the shared register untouched.
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_owner = owner_q;
  assign bus.o_q     = q_q;
  assign bus.o_busy  = busy_q;
endmodule

// File: doc/svi_rr_write_arbiter.md
Name: svi_rr_write_arbiter

Overview:
- Round-robin arbiter sharing one registered scalar resource (a shared write register, as held in an SVI member) among N_REQ requesters.
- One grant at a time via req/gnt handshake; the winner's data is written into the shared register on the grant edge.
- Optional lock keeps ownership for multi-cycle bursts.
- Sits between requester modules and the shared interface register. Its outputs feed that register and are read hierarchically by consumers.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- W, 8, width of the shared register and of each requester's data.
- LOCK_MAX, 16, maximum LOCK cycles before forced release. Used only with RR_ARB_LOCK_TIMEOUT_EN.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  N_REQ  per-requester request; held until gnt is seen.
- i_lock  input  N_REQ  per-requester burst-lock qualifier.
- i_wdata  input  N_REQ*W  packed data; slice k is [k*W +: W].
- o_gnt  output  N_REQ  one-hot grant (registered).
- o_owner  output  $clog2(N_REQ)  index of current/last winner.
- o_q  output  W  shared register value.
- o_busy  output  1  high in GNT or LOCK.
- o_timeout  output  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (i_rst=1 at posedge), taking effect on that edge from any state, including mid-LOCK:
  - outputs: o_gnt=0, o_owner=0, o_q=0, o_busy=0, o_timeout=0
  - internal: state=IDLE, ptr=0, lock counter=0
- Winner selection: first k with i_req[k]=1, scanning ptr, ptr+1, ..., wrapping modulo N_REQ. Combinational, with no dependence on i_lock.
- IDLE:
  - No request: hold; o_q keeps its value.
  - Any request: on the edge, o_gnt<=onehot(w), o_owner<=w, o_q<=i_wdata[w], ptr<=(w+1) mod N_REQ, state->GNT.
- GNT (o_gnt high exactly this cycle):
  - If i_req[w] && i_lock[w]: o_q<=i_wdata[w], o_gnt held, counter<=1, state->LOCK.
  - Else: o_gnt<=0, state->IDLE.
- LOCK:
  - While i_req[w] && i_lock[w]: o_q<=i_wdata[w] every cycle, o_gnt held, counter increments.
  - When either drops: o_gnt<=0, state->IDLE. o_q is not written on the exit edge.
- Requests from non-owners are ignored in GNT and LOCK; no queuing beyond the held req.
- Throughput: a single-shot grant costs 2 cycles (IDLE->GNT->IDLE). A requester holding req continuously is re-granted only after the others get their turn.
- Latency: req sampled in IDLE -> gnt and o_q update visible 1 cycle later.
- o_busy is registered: 1 iff next state is GNT or LOCK.
- o_owner holds the last winner in IDLE.
- Requester rule: drop i_req (or keep for lock) the cycle after seeing gnt. If req is still held without lock, that counts as a new request.

Optional Feature:
- Macro: RR_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - In LOCK, when counter reaches LOCK_MAX with lock still asserted: o_gnt<=0, state->IDLE, o_timeout<=1 for one cycle.
  - ptr is already past the owner, so the next arbitration favours others.
- Undefined: no counter; LOCK is unbounded; o_timeout tied 0; LOCK_MAX ignored.

Test Plan:
- Reset: assert i_rst 2 cycles with i_req=4'b1111 -> all outputs 0, state IDLE. First grant after release goes to requester 0.
- Round robin: i_req=4'b1111 held, each requester drops req on gnt, wdata[k]=8'h10+k.
  - Grants 0,1,2,3 every 2 cycles.
  - o_q sequence 8'h10,8'h11,8'h12,8'h13.
  - o_owner matches each grant.
- Wrap: ptr=3 after granting 2, i_req=4'b0101 -> grant 0 next, then 2.
- Lock burst: requester 1 holds req+lock 5 cycles with wdata 8'hA0..8'hA4; i_req[3]=1 throughout.
  - o_gnt=4'b0010 throughout; o_q tracks A0..A4.
  - After release, the next grant goes to 3.
- Timeout (macro on, LOCK_MAX=4): requester 2 holds lock indefinitely.
  - o_gnt drops after 4 LOCK cycles; o_timeout pulses once.
  - Requester 0 (pending) is granted next.
- Mid-lock reset: i_rst during LOCK -> next edge o_gnt=0, o_q=0, o_busy=0. Next grant starts from ptr=0.
